// File: rtl/pixel_write_arbiter.sv
// Merges two pixel write streams into one VGA write port. Each source has its own
// FIFO; the shared port is granted round-robin, one pixel per cycle. Off-screen
// pixels are dropped, and a pixel lost to a full FIFO sets a sticky overflow flag.
module pixel_write_arbiter #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] a_x,
    input  logic [6:0] a_y,
    input  logic [2:0] a_colour,
    input  logic       a_plot,
    input  logic [7:0] b_x,
    input  logic [6:0] b_y,
    input  logic [2:0] b_colour,
    input  logic       b_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       ovf_a,
    output logic       ovf_b,
    output logic       busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {GrantA, GrantB} grant_e;

    logic [17:0]      mem_a [DEPTH];
    logic [17:0]      mem_b [DEPTH];
    logic [PTR_W-1:0] wr_a_q, rd_a_q, wr_b_q, rd_b_q;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    grant_e           last_q, last_d;

    logic on_a, on_b, full_a, full_b;
    logic push_a, push_b, pop_a, pop_b;
    logic lost_a, lost_b;
    logic [17:0] head;

    // Push qualification, arbitration and FIFO occupancy for the coming edge.
    always_comb begin
        on_a   = a_plot && (32'(a_x) < SCREEN_W) && (32'(a_y) < SCREEN_H);
        on_b   = b_plot && (32'(b_x) < SCREEN_W) && (32'(b_y) < SCREEN_H);
        full_a = (cnt_a_q == CNT_W'(DEPTH));
        full_b = (cnt_b_q == CNT_W'(DEPTH));

        // Eligibility is pre-edge occupancy, so a same-cycle push is never bypassed.
        pop_a  = (cnt_a_q != '0) && ((cnt_b_q == '0) || (last_q == GrantB));
        pop_b  = (cnt_b_q != '0) && !pop_a;

        // A full FIFO still accepts when its head leaves on the same edge.
        push_a = on_a && (!full_a || pop_a);
        push_b = on_b && (!full_b || pop_b);
        lost_a = on_a && !push_a;
        lost_b = on_b && !push_b;

        cnt_a_d = cnt_a_q + CNT_W'(push_a) - CNT_W'(pop_a);
        cnt_b_d = cnt_b_q + CNT_W'(push_b) - CNT_W'(pop_b);

        last_d = last_q;
        head   = mem_b[rd_b_q];
        if (pop_a) begin
            last_d = GrantA;
            head   = mem_a[rd_a_q];
        end else if (pop_b) begin
            last_d = GrantB;
        end
    end

    // FIFO storage; contents need no reset because the counts gate every read.
    always_ff @(posedge clock) begin
        if (push_a) mem_a[wr_a_q] <= {a_x, a_y, a_colour};
        if (push_b) mem_b[wr_b_q] <= {b_x, b_y, b_colour};
    end

    // Pointers, counts, grant history, sticky flags and registered VGA outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_a_q     <= '0;
            rd_a_q     <= '0;
            wr_b_q     <= '0;
            rd_b_q     <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            last_q     <= GrantB;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            ovf_a      <= 1'b0;
            ovf_b      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push_a) wr_a_q <= wr_a_q + 1'b1;
            if (pop_a)  rd_a_q <= rd_a_q + 1'b1;
            if (push_b) wr_b_q <= wr_b_q + 1'b1;
            if (pop_b)  rd_b_q <= rd_b_q + 1'b1;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            last_q  <= last_d;
            if (lost_a) ovf_a <= 1'b1;
            if (lost_b) ovf_b <= 1'b1;
            vga_plot <= pop_a || pop_b;
            if (pop_a || pop_b) begin
                vga_x      <= head[17:10];
                vga_y      <= head[9:3];
                vga_colour <= head[2:0];
            end
            busy <= (cnt_a_d != '0) || (cnt_b_d != '0) || pop_a || pop_b;
        end
    end

endmodule
